// File: rtl/pipe_pkg.sv
// Shared constants for the RV32I front-end pipeline registers:
// datapath width, reset PC, NOP encoding and control-bundle bit indices.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    // Control bundle bit positions carried from ID to EX
    localparam int MEMREAD_BIT  = 0;
    localparam int REGWRITE_BIT = 1;
    localparam int MEMWRITE_BIT = 2;
    localparam int BRANCH_BIT   = 3;
    localparam int JUMP_BIT     = 4;
    localparam int ALUSRC_BIT   = 5;
    localparam int MEMTOREG_BIT = 6;
    localparam int AUIPC_BIT    = 7;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with enable, flush and synchronous reset.
// Ports: clk, rst (sync, active-high), en, flush (loads RST_VAL, beats en), d, q.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (flush) begin
            q_d = RST_VAL;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state of the 5-stage RV32I core: PC, IF/ID and ID/EX.
// Inputs: clk, rst (sync, active-high), pc_write, if_id_write, flush_id_ex,
//   branch_taken_ex/branch_target_ex, instr_if and the decoded ID fields.
// Outputs: pc_if, IF/ID contents (pc_id, instr_id, valid_id), ID/EX contents
//   (pc_ex, imm_ex, rdata*_ex, rs*_ex, rd_ex, ctrl_ex, valid_ex), mem_read_ex.
// Define PIPE_PERF_EN to add perf_stall_cnt and perf_flush_cnt outputs.
module pipe_front_regs #(
    parameter int               XLEN        = pipe_pkg::XLEN,
    parameter int               CTRL_W      = pipe_pkg::CTRL_W,
    parameter int               MEMREAD_BIT = pipe_pkg::MEMREAD_BIT,
    parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(pipe_pkg::RESET_PC),
    parameter logic [31:0]      NOP_INSTR   = pipe_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              flush_id_ex,
    input  logic              branch_taken_ex,
    input  logic [XLEN-1:0]   branch_target_ex,
    input  logic [31:0]       instr_if,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rd_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [XLEN-1:0]   rdata1_id,
    input  logic [XLEN-1:0]   rdata2_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    output logic [XLEN-1:0]   pc_if,
    output logic [XLEN-1:0]   pc_id,
    output logic [31:0]       instr_id,
    output logic              valid_id,
    output logic [XLEN-1:0]   pc_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [XLEN-1:0]   rdata1_ex,
    output logic [XLEN-1:0]   rdata2_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              valid_ex,
`ifdef PIPE_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              mem_read_ex
);

    localparam int IFID_W = XLEN + 32 + 1;
    localparam int IDEX_W = 4 * XLEN + 15 + CTRL_W + 1;

    localparam logic [IFID_W-1:0] IFID_RST = {{XLEN{1'b0}}, NOP_INSTR, 1'b0};

    // ---------------- PC ----------------
    logic            pc_en;
    logic [XLEN-1:0] pc_d;

    // A redirect loads the word-aligned target even while stalled
    always_comb begin
        pc_en = branch_taken_ex | pc_write;
        pc_d  = pc_if + XLEN'(4);
        if (branch_taken_ex) begin
            pc_d = {branch_target_ex[XLEN-1:2], 2'b00};
        end
    end

    pipe_reg #(
        .W       (XLEN),
        .RST_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_en),
        .flush (1'b0),
        .d     (pc_d),
        .q     (pc_if)
    );

    // ---------------- IF/ID ----------------
    logic [IFID_W-1:0] if_id_d;
    logic [IFID_W-1:0] if_id_q;

    assign if_id_d = {pc_if, instr_if, 1'b1};

    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL (IFID_RST)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .en    (if_id_write),
        .flush (branch_taken_ex),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign {pc_id, instr_id, valid_id} = if_id_q;

    // ---------------- ID/EX ----------------
    logic [IDEX_W-1:0] id_ex_d;
    logic [IDEX_W-1:0] id_ex_q;
    logic              id_ex_flush;

    assign id_ex_flush = branch_taken_ex | flush_id_ex;
    assign id_ex_d = {pc_id, imm_id, rdata1_id, rdata2_id,
                      rs1_id, rs2_id, rd_id, ctrl_id, valid_id};

    pipe_reg #(
        .W       (IDEX_W),
        .RST_VAL ('0)
    ) u_id_ex (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .flush (id_ex_flush),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    assign {pc_ex, imm_ex, rdata1_ex, rdata2_ex,
            rs1_ex, rs2_ex, rd_ex, ctrl_ex, valid_ex} = id_ex_q;

    assign mem_read_ex = ctrl_ex[MEMREAD_BIT] & valid_ex;

`ifdef PIPE_PERF_EN
    // ---------------- performance counters ----------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A redirect during a stall counts only as a flush
    always_comb begin
        stall_cnt_d = stall_cnt_q
                    + {31'd0, (~pc_write & ~branch_taken_ex)};
        flush_cnt_d = flush_cnt_q + {31'd0, branch_taken_ex};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: behavioural model checked every
// cycle plus literal checks of reset, stall, redirect and PC wrap.
module tb_pipe_front_regs;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0, if_id_write = 1'b0;
    logic        flush_id_ex = 1'b0, branch_taken_ex = 1'b0;
    logic [31:0] branch_target_ex = '0, instr_if = '0;
    logic [4:0]  rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic [31:0] imm_id = '0, rdata1_id = '0, rdata2_id = '0;
    logic [7:0]  ctrl_id = '0;
    logic [31:0] pc_if, pc_id, instr_id, pc_ex, imm_ex, rdata1_ex, rdata2_ex;
    logic        valid_id, valid_ex, mem_read_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [7:0]  ctrl_ex;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    pipe_front_regs dut (
        .clk(clk), .rst(rst), .pc_write(pc_write),
        .if_id_write(if_id_write), .flush_id_ex(flush_id_ex),
        .branch_taken_ex(branch_taken_ex),
        .branch_target_ex(branch_target_ex), .instr_if(instr_if),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .imm_id(imm_id), .rdata1_id(rdata1_id), .rdata2_id(rdata2_id),
        .ctrl_id(ctrl_id), .pc_if(pc_if), .pc_id(pc_id),
        .instr_id(instr_id), .valid_id(valid_id), .pc_ex(pc_ex),
        .imm_ex(imm_ex), .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .ctrl_ex(ctrl_ex), .valid_ex(valid_ex),
`ifdef PIPE_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .mem_read_ex(mem_read_ex)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model of the three stages
    typedef struct {
        logic [31:0] pc, imm, rd1, rd2;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctrl;
        logic        valid;
    } ex_t;

    bit          m_init = 0;
    logic [31:0] m_pc, m_pc_id, m_instr_id;
    logic        m_valid_id;
    ex_t         m_ex;
    logic [31:0] m_stall, m_flush;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_pc = RESET_PC;
            m_pc_id = 0;
            m_instr_id = NOP_INSTR;
            m_valid_id = 0;
            m_ex = '{default: '0};
            m_stall = 0;
            m_flush = 0;
        end else if (m_init) begin
            if (!pc_write && !branch_taken_ex) m_stall = m_stall + 1;
            if (branch_taken_ex) m_flush = m_flush + 1;
            if (branch_taken_ex || flush_id_ex) begin
                m_ex = '{default: '0};
            end else begin
                m_ex.pc = m_pc_id;     m_ex.imm = imm_id;
                m_ex.rd1 = rdata1_id;  m_ex.rd2 = rdata2_id;
                m_ex.rs1 = rs1_id;     m_ex.rs2 = rs2_id;
                m_ex.rd = rd_id;       m_ex.ctrl = ctrl_id;
                m_ex.valid = m_valid_id;
            end
            if (branch_taken_ex) begin
                m_pc_id = 0;
                m_instr_id = NOP_INSTR;
                m_valid_id = 0;
            end else if (if_id_write) begin
                m_pc_id = m_pc;
                m_instr_id = instr_if;
                m_valid_id = 1;
            end
            if (branch_taken_ex) m_pc = branch_target_ex & ~32'd3;
            else if (pc_write) m_pc = m_pc + 4;
        end
    end

    // Compare every cycle once the model has seen a reset
    always @(posedge clk) begin
        #1;
        if (m_init) begin
            chk("pc_if", pc_if, m_pc);
            chk("pc_id", pc_id, m_pc_id);
            chk("instr_id", instr_id, m_instr_id);
            chk("valid_id", valid_id, m_valid_id);
            chk("pc_ex", pc_ex, m_ex.pc);
            chk("imm_ex", imm_ex, m_ex.imm);
            chk("rdata1_ex", rdata1_ex, m_ex.rd1);
            chk("rdata2_ex", rdata2_ex, m_ex.rd2);
            chk("rs1_ex", rs1_ex, m_ex.rs1);
            chk("rs2_ex", rs2_ex, m_ex.rs2);
            chk("rd_ex", rd_ex, m_ex.rd);
            chk("ctrl_ex", ctrl_ex, m_ex.ctrl);
            chk("valid_ex", valid_ex, m_ex.valid);
            chk("mem_read_ex", mem_read_ex,
                m_ex.ctrl[MEMREAD_BIT] & m_ex.valid);
`ifdef PIPE_PERF_EN
            chk("perf_stall", perf_stall_cnt, m_stall);
            chk("perf_flush", perf_flush_cnt, m_flush);
`endif
        end
    end

    int vec = 0;

    task automatic set_id(input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [7:0] c);
        rs1_id = r1; rs2_id = r2; rd_id = rd; ctrl_id = c;
    endtask

    // One clock: drive at negedge, return 2 time units after posedge
    task automatic cyc(input logic r, input logic pw, input logic ifw,
                       input logic fl, input logic br,
                       input logic [31:0] tgt);
        @(negedge clk);
        vec++;
        rst = r; pc_write = pw; if_id_write = ifw;
        flush_id_ex = fl; branch_taken_ex = br; branch_target_ex = tgt;
        instr_if  = 32'hA000_0000 | 32'(vec);
        imm_id    = 32'h1000_0000 + 32'(vec);
        rdata1_id = 32'h2000_0000 ^ (32'(vec) << 4);
        rdata2_id = ~(32'h3000_0000 + 32'(vec));
        @(posedge clk);
        #2;
    endtask

    logic [31:0] saved_pc, saved_instr;

    initial begin
        // 1: reset and sequential fetch
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 32'h55);
        chk("rst_pc", pc_if, 32'h0);
        chk("rst_instr_id", instr_id, 32'h13);
        chk("rst_valid_id", valid_id, 1'b0);
        chk("rst_valid_ex", valid_ex, 1'b0);
        set_id(1, 2, 3, 8'h02);
        cyc(0, 1, 1, 0, 0, 0);
        chk("seq_pc4", pc_if, 32'h4);
        chk("seq_valid_id", valid_id, 1'b1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("seq_pc8", pc_if, 32'h8);
        cyc(0, 1, 1, 0, 0, 0);
        chk("seq_pc12", pc_if, 32'hC);
        chk("seq_pc_id", pc_id, 32'h8);

        // 2: load-use stall
        set_id(1, 2, 5, 8'h01);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lu_mem_read", mem_read_ex, 1'b1);
        chk("lu_rd_load", rd_ex, 5'd5);
        saved_pc = pc_if;
        saved_instr = instr_id;
        set_id(5, 6, 7, 8'h02);
        cyc(0, 0, 0, 1, 0, 0);
        chk("lu_pc_hold", pc_if, saved_pc);
        chk("lu_instr_hold", instr_id, saved_instr);
        chk("lu_bubble", valid_ex, 1'b0);
        chk("lu_bubble_mr", mem_read_ex, 1'b0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lu_cons_rd", rd_ex, 5'd7);
        chk("lu_cons_rs1", rs1_ex, 5'd5);
        chk("lu_cons_valid", valid_ex, 1'b1);
        chk("lu_pc_resume", pc_if, saved_pc + 4);

        // illegal combo: PC advances, IF/ID holds
        saved_instr = instr_id;
        cyc(0, 1, 0, 0, 0, 0);
        chk("ill_instr_hold", instr_id, saved_instr);
        chk("ill_pc_adv", pc_if, saved_pc + 8);

        // 3: redirect from pc_if=0x40 to 0x103
        while (pc_if != 32'h40 && vec < 200) cyc(0, 1, 1, 0, 0, 0);
        chk("br_pre_pc", pc_if, 32'h40);
        cyc(0, 1, 1, 0, 1, 32'h103);
        chk("br_pc", pc_if, 32'h100);
        chk("br_instr_id", instr_id, 32'h13);
        chk("br_valid_id", valid_id, 1'b0);
        chk("br_valid_ex", valid_ex, 1'b0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);

        // 4: redirect together with a stall
        cyc(0, 0, 0, 1, 1, 32'h200);
        chk("brst_pc", pc_if, 32'h200);
        chk("brst_valid_id", valid_id, 1'b0);
        chk("brst_valid_ex", valid_ex, 1'b0);
        chk("brst_pc_id", pc_id, 32'h0);

        // 5: PC wrap
        cyc(0, 1, 1, 0, 1, 32'hFFFF_FFFE);
        chk("wrap_pre", pc_if, 32'hFFFF_FFFC);
        cyc(0, 1, 1, 0, 0, 0);
        chk("wrap_pc", pc_if, 32'h0);
        chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);

        // reset in the middle of a redirect and stall
        cyc(1, 0, 0, 1, 1, 32'h80);
        chk("mid_rst_pc", pc_if, 32'h0);
        chk("mid_rst_valid_id", valid_id, 1'b0);

`ifdef PIPE_PERF_EN
        // 6: three stalls and two redirects
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 1, 32'h300);
        cyc(0, 0, 0, 1, 1, 32'h400);
        chk("perf_stall3", perf_stall_cnt, 32'd3);
        chk("perf_flush2", perf_flush_cnt, 32'd2);
        cyc(1, 0, 0, 0, 1, 0);
        chk("perf_rst_stall", perf_stall_cnt, 32'd0);
        chk("perf_rst_flush", perf_flush_cnt, 32'd0);
`endif

        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
